// File: rtl/iob_axistream_in_packer_pkg.sv
// Shared configuration for the AXIS-to-32-bit word packer: word geometry and
// FIFO entry layout derived from the beat width.
package iob_axistream_in_packer_pkg;

   localparam int WORD_W = 32;

   // Beats that fit in one 32-bit word (N).
   function automatic int beats_per_word(input int tdata_w);
      return WORD_W / tdata_w;
   endfunction

   // Width of a beat count that must hold 0..N inclusive (CNT_W).
   function automatic int cnt_width(input int tdata_w);
      return $clog2(WORD_W / tdata_w) + 1;
   endfunction

   // FIFO entry is {nbeats, tlast, data}.
   function automatic int entry_width(input int tdata_w);
      return WORD_W + 1 + cnt_width(tdata_w);
   endfunction

endpackage

// File: rtl/iob_axistream_in_wfifo.sv
// Synchronous show-ahead word FIFO; head entry is presented whenever valid_o
// is high and reads as zero when empty.
module iob_axistream_in_wfifo #(
   parameter int W          = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk_i,
   input  logic                  arst_n_i,
   input  logic                  cke_i,
   input  logic                  clr_i,
   input  logic                  push_i,
   input  logic [W-1:0]          push_data_i,
   input  logic                  pop_i,
   output logic [W-1:0]          data_o,
   output logic                  valid_o,
   output logic                  full_o,
   output logic [DEPTH_LOG2:0]   level_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [W-1:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   wptr_q, rptr_q;
   logic [DEPTH_LOG2:0]     level_q;
   logic                    do_push, do_pop;

   assign valid_o = (level_q != '0);
   assign full_o  = (level_q == FULL_LVL);
   assign level_o = level_q;
   assign data_o  = valid_o ? mem[rptr_q] : '0;

   // A pop request against an empty FIFO is simply dropped.
   assign do_push = cke_i & ~clr_i & push_i & ~full_o;
   assign do_pop  = cke_i & ~clr_i & pop_i & valid_o;

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wptr_q] <= push_data_i;
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (cke_i) begin
         if (clr_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
         end else begin
            if (do_push) wptr_q <= wptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            if (do_pop)  rptr_q <= rptr_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            case ({do_push, do_pop})
               2'b10:   level_q <= level_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
               2'b01:   level_q <= level_q - {{DEPTH_LOG2{1'b0}}, 1'b1};
               default: level_q <= level_q;
            endcase
         end
      end
   end

endmodule

// File: rtl/iob_axistream_in_packer.sv
// Packs TDATA_W-bit AXI-Stream beats little-endian into 32-bit words, closing a
// word on the N-th beat or on tlast, and queues words with their beat count.
module iob_axistream_in_packer
   import iob_axistream_in_packer_pkg::*;
#(
   parameter  int TDATA_W         = 8,
   parameter  int FIFO_DEPTH_LOG2 = 4,
   localparam int CNT_W           = cnt_width(TDATA_W)
) (
   input  logic                       clk_i,
   input  logic                       arst_n_i,
   input  logic                       cke_i,
   input  logic                       sw_rst_i,
   input  logic                       enable_i,
   input  logic [TDATA_W-1:0]         axis_tdata_i,
   input  logic                       axis_tvalid_i,
   output logic                       axis_tready_o,
   input  logic                       axis_tlast_i,
   output logic [WORD_W-1:0]          tdata_o,
   output logic                       tvalid_o,
   input  logic                       tready_i,
   output logic                       tlast_o,
   output logic [CNT_W-1:0]           nbeats_o,
   output logic [FIFO_DEPTH_LOG2:0]   level_o,
   input  logic [FIFO_DEPTH_LOG2:0]   threshold_i,
   output logic                       threshold_o
);

   localparam int N       = beats_per_word(TDATA_W);
   localparam int ENTRY_W = entry_width(TDATA_W);

   logic [WORD_W-1:0]   data_q, word_nxt;
   logic [CNT_W-1:0]    cnt_q;
   logic                full, beat_acc, word_done;
   logic [ENTRY_W-1:0]  push_entry, head_entry;

   // Full is taken from the registered level, so a same-cycle pop only frees
   // the input on the following cycle.
   assign axis_tready_o = arst_n_i & enable_i & ~full & ~sw_rst_i;
   assign beat_acc      = cke_i & axis_tvalid_i & axis_tready_o;
   assign word_done     = beat_acc & (axis_tlast_i | (cnt_q == CNT_W'(N-1)));

   always_comb begin
      word_nxt = data_q;
      for (int k = 0; k < N; k++) begin
         if (cnt_q == CNT_W'(k)) word_nxt[k*TDATA_W +: TDATA_W] = axis_tdata_i;
      end
   end

   assign push_entry = {cnt_q + CNT_W'(1), axis_tlast_i, word_nxt};

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (cke_i) begin
         if (sw_rst_i || word_done) begin
            data_q <= '0;
            cnt_q  <= '0;
         end else if (beat_acc) begin
            data_q <= word_nxt;
            cnt_q  <= cnt_q + CNT_W'(1);
         end
      end
   end

   iob_axistream_in_wfifo #(
      .W          (ENTRY_W),
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_wfifo (
      .clk_i       (clk_i),
      .arst_n_i    (arst_n_i),
      .cke_i       (cke_i),
      .clr_i       (sw_rst_i),
      .push_i      (word_done),
      .push_data_i (push_entry),
      .pop_i       (tready_i),
      .data_o      (head_entry),
      .valid_o     (tvalid_o),
      .full_o      (full),
      .level_o     (level_o)
   );

   assign {nbeats_o, tlast_o, tdata_o} = head_entry;
   assign threshold_o = (level_o >= threshold_i);

endmodule

// File: tb/tb_iob_axistream_in_packer.sv
// Scoreboard bench for the AXIS word packer: a byte-list reference model runs
// in a negedge monitor while directed and random stimulus drives the inputs.
module tb_iob_axistream_in_packer;

   localparam int TDATA_W = 8;
   localparam int FDL     = 2;
   localparam int DEPTH   = 4;
   localparam int N       = 4;
   localparam int CNT_W   = 3;

   logic               clk_i = 1'b0;
   logic               arst_n_i = 1'b0;
   logic               cke_i = 1'b1;
   logic               sw_rst_i = 1'b0;
   logic               enable_i = 1'b1;
   logic [TDATA_W-1:0] axis_tdata_i = '0;
   logic               axis_tvalid_i = 1'b0;
   logic               axis_tlast_i = 1'b0;
   logic               tready_i = 1'b0;
   logic [FDL:0]       threshold_i = '0;
   logic               axis_tready_o;
   logic [31:0]        tdata_o;
   logic               tvalid_o;
   logic               tlast_o;
   logic [CNT_W-1:0]   nbeats_o;
   logic [FDL:0]       level_o;
   logic               threshold_o;

   iob_axistream_in_packer #(.TDATA_W(TDATA_W), .FIFO_DEPTH_LOG2(FDL)) dut (
      .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .sw_rst_i(sw_rst_i),
      .enable_i(enable_i), .axis_tdata_i(axis_tdata_i), .axis_tvalid_i(axis_tvalid_i),
      .axis_tready_o(axis_tready_o), .axis_tlast_i(axis_tlast_i), .tdata_o(tdata_o),
      .tvalid_o(tvalid_o), .tready_i(tready_i), .tlast_o(tlast_o), .nbeats_o(nbeats_o),
      .level_o(level_o), .threshold_i(threshold_i), .threshold_o(threshold_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          nb;
   } word_t;

   int          checks = 0;
   int          errors = 0;
   bit          streaming = 1'b0;
   word_t       exp_q[$];
   logic [7:0]  part_q[$];
   bit          m_rdy;
   word_t       m_w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: beats collect in a byte list; a word is formed from the
   // list when it holds N bytes or the beat carries tlast.
   always @(negedge clk_i) begin
      if (!arst_n_i) begin
         chk("rst_axis_tready", axis_tready_o, 0);
         chk("rst_tvalid", tvalid_o, 0);
         chk("rst_tdata", tdata_o, 0);
         chk("rst_tlast", tlast_o, 0);
         chk("rst_nbeats", nbeats_o, 0);
         chk("rst_level", level_o, 0);
         chk("rst_threshold", threshold_o, threshold_i == 0);
         exp_q.delete();
         part_q.delete();
      end else begin
         m_rdy = enable_i && !sw_rst_i && (exp_q.size() < DEPTH);
         chk("level", level_o, exp_q.size());
         chk("tvalid", tvalid_o, exp_q.size() != 0);
         chk("axis_tready", axis_tready_o, m_rdy);
         chk("threshold", threshold_o, exp_q.size() >= int'(threshold_i));
         if (exp_q.size() != 0) begin
            chk("head_tdata", tdata_o, exp_q[0].data);
            chk("head_tlast", tlast_o, exp_q[0].last);
            chk("head_nbeats", nbeats_o, exp_q[0].nb);
         end
         if (streaming) chk("stream_level_le1", level_o <= 1, 1);
         if (cke_i) begin
            if (sw_rst_i) begin
               exp_q.delete();
               part_q.delete();
            end else begin
               if (exp_q.size() != 0 && tready_i) void'(exp_q.pop_front());
               if (axis_tvalid_i && m_rdy) begin
                  part_q.push_back(axis_tdata_i);
                  if (part_q.size() == N || axis_tlast_i) begin
                     m_w.data = '0;
                     foreach (part_q[i]) m_w.data = m_w.data | (32'(part_q[i]) << (8 * i));
                     m_w.last = axis_tlast_i;
                     m_w.nb   = part_q.size();
                     exp_q.push_back(m_w);
                     part_q.delete();
                  end
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // Holds a beat until the DUT takes it; returns just after the accepting edge.
   task automatic send_beat(input logic [7:0] d, input logic l);
      bit acc = 1'b0;
      int n = 0;
      axis_tdata_i  = d;
      axis_tlast_i  = l;
      axis_tvalid_i = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk_i);
         acc = axis_tready_o && cke_i;
         @(posedge clk_i);
         #1;
         n++;
      end
      chk("beat_accepted", acc, 1);
   endtask

   task automatic pop_one();
      tready_i = 1'b1;
      cycles(1);
      tready_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      arst_n_i = 1'b1;
      cycles(2);

      // four-beat packet
      send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("w4_tvalid", tvalid_o, 1);
      chk("w4_tdata", tdata_o, 32'h44332211);
      chk("w4_nbeats", nbeats_o, 4);
      chk("w4_tlast", tlast_o, 1);
      @(posedge clk_i); #1;
      pop_one();

      // short packet, upper bytes zero
      send_beat(8'hAA, 0); send_beat(8'hBB, 1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("w2_tdata", tdata_o, 32'h0000BBAA);
      chk("w2_nbeats", nbeats_o, 2);
      chk("w2_tlast", tlast_o, 1);
      @(posedge clk_i); #1;
      pop_one();

      // fill to full, then one pop
      for (int w = 0; w < DEPTH; w++)
         for (int b = 0; b < N; b++) send_beat(8'($urandom), b == N-1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("full_level", level_o, 4);
      chk("full_axis_tready", axis_tready_o, 0);
      @(posedge clk_i); #1;
      tready_i = 1'b1;
      @(negedge clk_i);
      chk("full_pop_same_cycle_tready", axis_tready_o, 0);
      @(posedge clk_i); #1;
      tready_i = 1'b0;
      @(negedge clk_i);
      chk("after_pop_level", level_o, 3);
      chk("after_pop_axis_tready", axis_tready_o, 1);
      @(posedge clk_i); #1;
      tready_i = 1'b1;
      cycles(6);
      tready_i = 1'b0;

      // full-rate streaming across pointer wrap
      streaming = 1'b1;
      tready_i  = 1'b1;
      for (int w = 0; w < 64; w++)
         for (int b = 0; b < N; b++) send_beat(8'($urandom), b == N-1);
      axis_tvalid_i = 1'b0;
      cycles(4);
      streaming = 1'b0;
      tready_i  = 1'b0;
      chk("stream_drained", level_o, 0);

      // enable gap inside a word
      send_beat(8'h01, 0); send_beat(8'h02, 0);
      enable_i = 1'b0;
      axis_tdata_i = 8'hEE;
      cycles(10);
      enable_i = 1'b1;
      send_beat(8'h03, 0); send_beat(8'h04, 0);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("gap_tdata", tdata_o, 32'h04030201);
      chk("gap_nbeats", nbeats_o, 4);
      chk("gap_tlast", tlast_o, 0);
      @(posedge clk_i); #1;

      // soft reset drops stored and partial words
      send_beat(8'h5A, 0); send_beat(8'h5B, 0); send_beat(8'h5C, 0); send_beat(8'h5D, 1);
      send_beat(8'h99, 0);
      axis_tvalid_i = 1'b0;
      sw_rst_i = 1'b1;
      cycles(1);
      sw_rst_i = 1'b0;
      @(negedge clk_i);
      chk("swrst_level", level_o, 0);
      chk("swrst_tvalid", tvalid_o, 0);
      @(posedge clk_i); #1;
      send_beat(8'h55, 1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("swrst_next_tdata", tdata_o, 32'h00000055);
      chk("swrst_next_nbeats", nbeats_o, 1);
      @(posedge clk_i); #1;
      pop_one();

      // threshold and async reset mid-packet
      threshold_i = 3'd3;
      send_beat(8'hC1, 1); send_beat(8'hC2, 1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("thr_below", threshold_o, 0);
      @(posedge clk_i); #1;
      send_beat(8'hC3, 1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("thr_level3", level_o, 3);
      chk("thr_rise", threshold_o, 1);
      @(posedge clk_i); #1;
      send_beat(8'h66, 0);
      arst_n_i = 1'b0;
      @(negedge clk_i);
      chk("arst_tvalid", tvalid_o, 0);
      chk("arst_level", level_o, 0);
      chk("arst_threshold", threshold_o, 0);
      @(posedge clk_i); #1;
      arst_n_i = 1'b1;
      axis_tvalid_i = 1'b0;
      cycles(1);
      send_beat(8'h77, 1);
      axis_tvalid_i = 1'b0;
      @(negedge clk_i);
      chk("post_arst_tdata", tdata_o, 32'h00000077);
      chk("post_arst_nbeats", nbeats_o, 1);
      @(posedge clk_i); #1;
      pop_one();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cke_i         = ($urandom % 8) != 0;
         enable_i      = ($urandom % 6) != 0;
         sw_rst_i      = ($urandom % 60) == 0;
         axis_tvalid_i = ($urandom % 3) != 0;
         axis_tdata_i  = 8'($urandom);
         axis_tlast_i  = ($urandom % 5) == 0;
         tready_i      = ($urandom % 2) != 0;
         threshold_i   = 3'($urandom_range(0, 4));
         cycles(1);
      end
      cke_i = 1'b1; enable_i = 1'b1; sw_rst_i = 1'b0;
      axis_tvalid_i = 1'b0; tready_i = 1'b1;
      cycles(8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
